// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction fields, shadow-slot record.
package pipe_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 4;

  localparam logic [OPC_W-1:0] LOAD_OPCODE = 4'h8;
  localparam logic [OPC_W-1:0] NOP_OPCODE  = 4'h0;
  localparam logic [OPC_W-1:0] LI_OPCODE   = 4'hE;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RA_MSB  = 7;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned RB_MSB  = 3;
  localparam int unsigned RB_LSB  = 0;

  typedef struct packed {
    logic             valid;
    logic             is_load;
    logic [REG_W-1:0] rd;
  } slot_t;

  typedef struct packed {
    logic ra_used;
    logic rb_used;
    logic writes_rd;
    logic is_load;
  } src_info_t;

endpackage

// File: rtl/src_decode.sv
// Classifies an instruction by which register fields it reads and writes.
module src_decode #(
  parameter logic [3:0] LOAD_OPCODE = pipe_pkg::LOAD_OPCODE,
  parameter logic [3:0] NOP_OPCODE  = pipe_pkg::NOP_OPCODE,
  parameter logic [3:0] LI_OPCODE   = pipe_pkg::LI_OPCODE
) (
  input  logic [pipe_pkg::INSTR_W-1:0] instr_i,
  output pipe_pkg::src_info_t          info_c_o
);

  logic [pipe_pkg::OPC_W-1:0] opc;
  logic                       is_nop;
  logic                       is_li;

  assign opc    = instr_i[pipe_pkg::OPC_MSB:pipe_pkg::OPC_LSB];
  assign is_nop = (opc == NOP_OPCODE);
  assign is_li  = (opc == LI_OPCODE);

  // NOP and LI read nothing; NOP alone writes nothing.
  always_comb begin
    info_c_o           = '0;
    info_c_o.ra_used   = ~is_nop & ~is_li;
    info_c_o.rb_used   = ~is_nop & ~is_li;
    info_c_o.writes_rd = ~is_nop;
    info_c_o.is_load   = (opc == LOAD_OPCODE);
  end

endmodule

// File: rtl/load_use_interlock.sv
// Load-use hazard detector: two-slot shadow of EX/MEM destinations, stall and stall counters.
module load_use_interlock #(
  parameter logic [3:0] LOAD_OPCODE = pipe_pkg::LOAD_OPCODE,
  parameter logic [3:0] NOP_OPCODE  = pipe_pkg::NOP_OPCODE,
  parameter logic [3:0] LI_OPCODE   = pipe_pkg::LI_OPCODE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         dec_valid,
  input  logic [pipe_pkg::INSTR_W-1:0] dec_instruction,
  output logic                         stall,
  output logic [1:0]                   stall_run,
  output logic [15:0]                  stall_total
);

  localparam int unsigned RUN_W   = 2;
  localparam int unsigned TOTAL_W = 16;
  localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(2);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  pipe_pkg::src_info_t         dec_info;
  logic [pipe_pkg::REG_W-1:0]  src_a;
  logic [pipe_pkg::REG_W-1:0]  src_b;
  logic [pipe_pkg::REG_W-1:0]  dst;

  pipe_pkg::slot_t             ex_q, ex_d;
  pipe_pkg::slot_t             mem_q;
  logic [RUN_W-1:0]            run_q, run_d;
  logic [TOTAL_W-1:0]          total_q, total_d;

  logic                        hit_a_c;
  logic                        hit_b_c;
  logic                        hazard_c;

  src_decode #(
    .LOAD_OPCODE (LOAD_OPCODE),
    .NOP_OPCODE  (NOP_OPCODE),
    .LI_OPCODE   (LI_OPCODE)
  ) u_src_decode (
    .instr_i  (dec_instruction),
    .info_c_o (dec_info)
  );

  assign src_a = dec_instruction[pipe_pkg::RA_MSB:pipe_pkg::RA_LSB];
  assign src_b = dec_instruction[pipe_pkg::RB_MSB:pipe_pkg::RB_LSB];
  assign dst   = dec_instruction[pipe_pkg::RD_MSB:pipe_pkg::RD_LSB];

  // True when an in-flight load will write a nonzero register equal to src.
  function automatic logic load_hit(input pipe_pkg::slot_t s,
                                    input logic [pipe_pkg::REG_W-1:0] src);
    return s.valid && s.is_load && (s.rd != '0) && (src != '0) && (s.rd == src);
  endfunction

  // Compare each used source against both load slots.
  always_comb begin
    hit_a_c  = dec_info.ra_used && (load_hit(ex_q, src_a) || load_hit(mem_q, src_a));
    hit_b_c  = dec_info.rb_used && (load_hit(ex_q, src_b) || load_hit(mem_q, src_b));
    hazard_c = dec_valid && (hit_a_c || hit_b_c);
  end

  // Stall is combinational so decode holds in the same cycle; reset or flush mask it.
  assign stall = hazard_c & ~flush & rst_n;

  // Next-state for the EX slot and the two counters.
  always_comb begin
    ex_d    = '0;
    run_d   = '0;
    total_d = total_q;
    if (!stall && dec_valid && dec_info.writes_rd) begin
      ex_d.valid   = 1'b1;
      ex_d.is_load = dec_info.is_load;
      ex_d.rd      = dst;
    end
    if (stall) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
      if (total_q != TOTAL_MAX) begin
        total_d = total_q + TOTAL_W'(1);
      end
    end
  end

  // Shadow slots and run counter clear on reset or flush; the total clears only on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      run_q   <= '0;
      total_q <= '0;
    end else begin
      total_q <= total_d;
      if (flush) begin
        ex_q  <= '0;
        mem_q <= '0;
        run_q <= '0;
      end else begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        run_q <= run_d;
      end
    end
  end

  assign stall_run   = run_q;
  assign stall_total = total_q;

endmodule

// File: tb/tb_load_use_interlock.sv
// Directed scoreboard bench for load_use_interlock.
module tb_load_use_interlock;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dec_valid;
  logic [15:0] dec_instruction;
  logic        stall;
  logic [1:0]  stall_run;
  logic [15:0] stall_total;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic        force_sat;
    logic [15:0] instr;
    logic        e_stall;
    logic [1:0]  e_run;
    logic [15:0] e_total;
  } step_t;

  typedef struct {
    int          idx;
    logic        e_stall;
    logic [1:0]  e_run;
    logic [15:0] e_total;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];

  load_use_interlock dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .dec_valid       (dec_valid),
    .dec_instruction (dec_instruction),
    .stall           (stall),
    .stall_run       (stall_run),
    .stall_total     (stall_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic v, input logic f, input logic fs,
                     input logic [15:0] ins, input logic es, input logic [1:0] er,
                     input logic [15:0] et);
    step_t s;
    s.rst_n = r; s.valid = v; s.flush = f; s.force_sat = fs; s.instr = ins;
    s.e_stall = es; s.e_run = er; s.e_total = et;
    steps.push_back(s);
  endtask

  // Monitor: compare DUT outputs against the scoreboard on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total_cnt++;
        if (stall !== e.e_stall) begin
          bad_cnt++;
          $display("FAIL stall step=%0d got=%b want=%b", e.idx, stall, e.e_stall);
        end
        total_cnt++;
        if (stall_run !== e.e_run) begin
          bad_cnt++;
          $display("FAIL stall_run step=%0d got=%0d want=%0d", e.idx, stall_run, e.e_run);
        end
        total_cnt++;
        if (stall_total !== e.e_total) begin
          bad_cnt++;
          $display("FAIL stall_total step=%0d got=%h want=%h", e.idx, stall_total, e.e_total);
        end
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #20000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // Driver: apply one table row per cycle and push its expected outputs.
  initial begin
    exp_t e;
    rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b1; dec_instruction = 16'h1432;

    // reset held with a would-be consumer present
    add(0,1,0,0,16'h1432, 0,0,16'd0);
    add(0,1,0,0,16'h1432, 0,0,16'd0);
    add(0,1,0,0,16'h1432, 0,0,16'd0);
    // back-to-back load-use: two stall cycles
    add(1,1,0,0,16'h8310, 0,0,16'd0);
    add(1,1,0,0,16'h1432, 1,0,16'd0);
    add(1,1,0,0,16'h1432, 1,1,16'd1);
    add(1,1,0,0,16'h1432, 0,2,16'd2);
    add(1,0,0,0,16'h0000, 0,0,16'd2);
    // one independent instruction in between: one stall cycle
    add(1,1,0,0,16'h8310, 0,0,16'd2);
    add(1,1,0,0,16'h1521, 0,0,16'd2);
    add(1,1,0,0,16'h1432, 1,0,16'd2);
    add(1,1,0,0,16'h1432, 0,1,16'd3);
    add(1,0,0,0,16'h0000, 0,0,16'd3);
    // load to r0 never hazards
    add(1,1,0,0,16'h8010, 0,0,16'd3);
    add(1,1,0,0,16'h1400, 0,0,16'd3);
    add(1,0,0,0,16'h0000, 0,0,16'd3);
    // ALU producer never stalls
    add(1,1,0,0,16'h1310, 0,0,16'd3);
    add(1,1,0,0,16'h1432, 0,0,16'd3);
    add(1,0,0,0,16'h0000, 0,0,16'd3);
    // LI reads nothing
    add(1,1,0,0,16'h8310, 0,0,16'd3);
    add(1,1,0,0,16'hE300, 0,0,16'd3);
    add(1,0,0,0,16'h0000, 0,0,16'd3);
    add(1,0,0,0,16'h0000, 0,0,16'd3);
    // flush on the first would-be stall cycle
    add(1,1,0,0,16'h8310, 0,0,16'd3);
    add(1,1,1,0,16'h1432, 0,0,16'd3);
    add(1,1,0,0,16'h1432, 0,0,16'd3);
    add(1,0,0,0,16'h0000, 0,0,16'd3);
    // flush mid-run clears run but keeps total
    add(1,1,0,0,16'h8310, 0,0,16'd3);
    add(1,1,0,0,16'h1432, 1,0,16'd3);
    add(1,1,1,0,16'h1432, 0,1,16'd4);
    add(1,1,0,0,16'h1432, 0,0,16'd4);
    add(1,0,0,0,16'h0000, 0,0,16'd4);
    // sources hit different slots: still a single 2-cycle run
    add(1,1,0,0,16'h8310, 0,0,16'd4);
    add(1,1,0,0,16'h8420, 0,0,16'd4);
    add(1,1,0,0,16'h1443, 1,0,16'd4);
    add(1,1,0,0,16'h1443, 1,1,16'd5);
    add(1,1,0,0,16'h1443, 0,2,16'd6);
    add(1,0,0,0,16'h0000, 0,0,16'd6);
    // reset mid-stall drops stall at once, clears all at next edge
    add(1,1,0,0,16'h8310, 0,0,16'd6);
    add(1,1,0,0,16'h1432, 1,0,16'd6);
    add(0,1,0,0,16'h1432, 0,1,16'd7);
    add(1,1,0,0,16'h1432, 0,0,16'd0);
    add(1,0,0,0,16'h0000, 0,0,16'd0);
    // saturation from a preloaded 16'hFFFE
    add(1,0,0,1,16'h0000, 0,0,16'hFFFE);
    add(1,1,0,0,16'h8310, 0,0,16'hFFFE);
    add(1,1,0,0,16'h1432, 1,0,16'hFFFE);
    add(1,1,0,0,16'h1432, 1,1,16'hFFFF);
    add(1,1,0,0,16'h1432, 0,2,16'hFFFF);
    add(1,0,0,0,16'h0000, 0,0,16'hFFFF);
    add(1,1,0,0,16'h8310, 0,0,16'hFFFF);
    add(1,1,0,0,16'h1432, 1,0,16'hFFFF);
    add(1,1,0,0,16'h1432, 1,1,16'hFFFF);
    add(1,1,0,0,16'h1432, 0,2,16'hFFFF);
    add(1,0,0,0,16'h0000, 0,0,16'hFFFF);

    // first edge under reset establishes known state
    @(posedge clk);
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n           = steps[i].rst_n;
      dec_valid       = steps[i].valid;
      flush           = steps[i].flush;
      dec_instruction = steps[i].instr;
      if (steps[i].force_sat) begin
        #1 force dut.total_q = 16'hFFFE;
        #1 release dut.total_q;
      end
      e.idx = i; e.e_stall = steps[i].e_stall; e.e_run = steps[i].e_run;
      e.e_total = steps[i].e_total;
      sb.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (sb.size() != 0) begin
      bad_cnt++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
